// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: handshake and status bundle for sync_fifo_flags.
//   master : producer/consumer side; drives w_inc, r_inc, clr_err and wr_data.
//   slave  : FIFO side; drives rd_data, count and all status flags.
interface sync_fifo_flags_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR       = 6
);
  logic                  w_inc;
  logic                  r_inc;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_inc, r_inc, clr_err, wr_data,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_inc, r_inc, clr_err, wr_data,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and optional first-word-fall-through reads.
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of sync_fifo_flags_if (requests and write data in; read data,
//          count and flags out)
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR       = 6,
  parameter int unsigned AF_LEVEL   = (1 << ADDR) - 4,
  parameter int unsigned AE_LEVEL   = 4,
  parameter bit          FWFT       = 1'b0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flags_if.slave bus
);

  localparam int unsigned   DEPTH    = 1 << ADDR;
  localparam logic [ADDR:0] DepthCnt = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR:0] AfCnt    = (ADDR + 1)'(AF_LEVEL);
  localparam logic [ADDR:0] AeCnt    = (ADDR + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]       wptr_q, rptr_q;
  logic [ADDR:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  full, empty;
  logic                  wr_ok, rd_ok;

  // Every flag is a decode of count_q, so flags cannot drift from the count.
  always_comb begin
    full    = (count_q == DepthCnt);
    empty   = (count_q == '0);
    wr_ok   = bus.w_inc && !full;
    rd_ok   = bus.r_inc && !empty;
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - 1'b1;
    end
    // Set has priority over clear.
    ovf_d = (bus.w_inc && full) || (ovf_q && !bus.clr_err);
    unf_d = (bus.r_inc && empty) || (unf_q && !bus.clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset; a reset only discards it logically via the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= bus.wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word shown directly; meaningless while empty.
      assign bus.rd_data = mem[rptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_q <= '0;
        end else if (rd_ok) begin
          rd_data_q <= mem[rptr_q];
        end
      end
      assign bus.rd_data = rd_data_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AfCnt);
  assign bus.almost_empty = (count_q <= AeCnt);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: drives one standard-mode and one FWFT-mode sync_fifo_flags with the
// same stimulus and checks both against a queue model every cycle, plus literal
// expectations at the boundary points.
module tb_sync_fifo_flags;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AF    = 60;
  localparam int unsigned AE    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_inc = 1'b0;
  logic          r_inc = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] wr_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR(AW)) bus_std ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR(AW)) bus_fw ();

  assign bus_std.w_inc   = w_inc;
  assign bus_std.r_inc   = r_inc;
  assign bus_std.clr_err = clr_err;
  assign bus_std.wr_data = wr_data;
  assign bus_fw.w_inc    = w_inc;
  assign bus_fw.r_inc    = r_inc;
  assign bus_fw.clr_err  = clr_err;
  assign bus_fw.wr_data  = wr_data;

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)
  ) dut_std (
    .clk(clk),
    .rst(rst),
    .bus(bus_std.slave)
  );

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .ADDR(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)
  ) dut_fw (
    .clk(clk),
    .rst(rst),
    .bus(bus_fw.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus sticky error bits.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            m_was_full, m_was_empty;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_was_full  = (q.size() == DEPTH);
      m_was_empty = (q.size() == 0);
      if (r_inc && !m_was_empty) m_rd = q.pop_front();
      if (w_inc && !m_was_full) q.push_back(wr_data);
      m_ovf = (w_inc && m_was_full) || (m_ovf && !clr_err);
      m_unf = (r_inc && m_was_empty) || (m_unf && !clr_err);
    end
  end

  // Per-cycle comparison, away from the rising edge.
  always @(negedge clk) begin
    chk("std_count", 32'(bus_std.count), q.size());
    chk("fw_count", 32'(bus_fw.count), q.size());
    chk("std_full", 32'(bus_std.full), 32'(q.size() == DEPTH));
    chk("fw_full", 32'(bus_fw.full), 32'(q.size() == DEPTH));
    chk("std_empty", 32'(bus_std.empty), 32'(q.size() == 0));
    chk("fw_empty", 32'(bus_fw.empty), 32'(q.size() == 0));
    chk("std_af", 32'(bus_std.almost_full), 32'(q.size() >= AF));
    chk("std_ae", 32'(bus_std.almost_empty), 32'(q.size() <= AE));
    chk("fw_ae", 32'(bus_fw.almost_empty), 32'(q.size() <= AE));
    chk("std_ovf", 32'(bus_std.overflow), 32'(m_ovf));
    chk("std_unf", 32'(bus_std.underflow), 32'(m_unf));
    chk("fw_ovf", 32'(bus_fw.overflow), 32'(m_ovf));
    chk("fw_unf", 32'(bus_fw.underflow), 32'(m_unf));
    chk("std_rd", 32'(bus_std.rd_data), 32'(m_rd));
    if (q.size() > 0) chk("fw_head", 32'(bus_fw.rd_data), 32'(q[0]));
  end

  task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
    w_inc   = w;
    r_inc   = r;
    wr_data = d;
    clr_err = c;
    @(posedge clk);
    #1;
    w_inc   = 1'b0;
    r_inc   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wp;
    int rp;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_count", 32'(bus_std.count), 0);
    chk("rst_empty", 32'(bus_std.empty), 1);
    chk("rst_ae", 32'(bus_std.almost_empty), 1);
    chk("rst_full", 32'(bus_std.full), 0);
    chk("rst_rd", 32'(bus_std.rd_data), 32'h00);

    // Reset in the middle of a write burst.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    chk("burst_count", 32'(bus_std.count), 10);
    w_inc   = 1'b1;
    wr_data = 8'h55;
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus_std.count), 0);
    chk("mid_rst_empty", 32'(bus_std.empty), 1);
    chk("mid_rst_full", 32'(bus_std.full), 0);
    chk("mid_rst_ae", 32'(bus_std.almost_empty), 1);
    chk("mid_rst_af", 32'(bus_std.almost_full), 0);
    chk("mid_rst_ovf", 32'(bus_std.overflow), 0);
    chk("mid_rst_unf", 32'(bus_std.underflow), 0);
    chk("mid_rst_rd", 32'(bus_std.rd_data), 32'h00);
    w_inc = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("unf_after_rst", 32'(bus_std.underflow), 1);
    chk("unf_count", 32'(bus_std.count), 0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("unf_cleared", 32'(bus_std.underflow), 0);

    // Fill to full.
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
      if (i == 58) chk("af_below", 32'(bus_std.almost_full), 0);
      if (i == 59) begin
        chk("af_at_60", 32'(bus_std.almost_full), 1);
        chk("count_60", 32'(bus_std.count), 60);
      end
      if (i == 62) chk("full_at_63", 32'(bus_std.full), 0);
    end
    chk("full_at_64", 32'(bus_std.full), 1);
    chk("count_64", 32'(bus_std.count), 64);
    chk("fw_head_a0", 32'(bus_fw.rd_data), 32'hA0);

    // Overflow and error clear.
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    chk("ovf_set", 32'(bus_std.overflow), 1);
    chk("ovf_count", 32'(bus_std.count), 64);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(bus_std.overflow), 0);
    step(1'b1, 1'b0, 8'hFF, 1'b1);
    chk("ovf_set_wins", 32'(bus_std.overflow), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Both requests at full: read wins, write overflows.
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("full_both_count", 32'(bus_std.count), 63);
    chk("full_both_ovf", 32'(bus_std.overflow), 1);
    chk("full_both_rd", 32'(bus_std.rd_data), 32'hA0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    for (int i = 1; i < 64; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_rd", 32'(bus_std.rd_data), 32'(8'(8'hA0 + i)));
    end
    chk("drain_empty", 32'(bus_std.empty), 1);
    chk("drain_last", 32'(bus_std.rd_data), 32'hDF);

    // Both requests at empty: write wins, read underflows.
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("empty_both_count", 32'(bus_std.count), 1);
    chk("empty_both_unf", 32'(bus_std.underflow), 1);
    chk("empty_both_head", 32'(bus_fw.rd_data), 32'h77);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("empty_both_rd", 32'(bus_std.rd_data), 32'h77);

    // FWFT presentation.
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    chk("fwft_5a", 32'(bus_fw.rd_data), 32'h5A);
    chk("fwft_not_empty", 32'(bus_fw.empty), 0);
    step(1'b1, 1'b0, 8'h5B, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_5b", 32'(bus_fw.rd_data), 32'h5B);
    chk("std_5a", 32'(bus_std.rd_data), 32'h5A);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_drained", 32'(bus_fw.empty), 1);

    // Both requests mid-range.
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    chk("mid_both_count", 32'(bus_std.count), 30);
    chk("mid_both_rd", 32'(bus_std.rd_data), 32'h00);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int p = 0; p < 4; p++) begin
      wp = (p % 2 == 0) ? 80 : 30;
      rp = (p % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(99) < wp), ($urandom_range(99) < rp), 8'($urandom), 1'b0);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
